// File: rtl/hp_video_emulator.sv
// Synthetic video source: raster timing, sync, luma test patterns and frame counter on one pixel clock.
// Optional build macro HP_EMU_NOISE_EN adds LFSR noise on VIDEO[1:0] during visible pixels.
module hp_video_emulator #(
  parameter int          H_VISIBLE        = 512,
  parameter int          H_FRONT          = 16,
  parameter int          H_SYNC           = 32,
  parameter int          H_BACK           = 80,
  parameter int          V_VISIBLE        = 384,
  parameter int          V_FRONT          = 4,
  parameter int          V_SYNC           = 4,
  parameter int          V_BACK           = 24,
  parameter bit          SYNC_ACTIVE_HIGH = 1'b0,
  parameter logic [9:0]  BLACK_LEVEL      = 10'd64,
  parameter logic [9:0]  WHITE_LEVEL      = 10'd940
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       ENABLE,
  input  logic [1:0] PATTERN,
  output logic       O_HS,
  output logic       O_VS,
  output logic [9:0] VIDEO,
  output logic       O_VISIBLE,
  output logic       FRAME_START,
  output logic [7:0] FRAME_COUNT
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
  localparam int HW      = $clog2(H_TOTAL);
  localparam int VW      = $clog2(V_TOTAL);

  localparam logic [HW-1:0] H_VIS   = HW'(H_VISIBLE);
  localparam logic [HW-1:0] H_SSTRT = HW'(H_VISIBLE + H_FRONT);
  localparam logic [HW-1:0] H_SEND  = HW'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [HW-1:0] H_LAST  = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_VIS   = VW'(V_VISIBLE);
  localparam logic [VW-1:0] V_SSTRT = VW'(V_VISIBLE + V_FRONT);
  localparam logic [VW-1:0] V_SEND  = VW'(V_VISIBLE + V_FRONT + V_SYNC);
  localparam logic [VW-1:0] V_LAST  = VW'(V_TOTAL - 1);
  localparam logic          SYNC_ON = SYNC_ACTIVE_HIGH;

  typedef enum logic [1:0] {
    PAT_BLACK = 2'd0,
    PAT_WHITE = 2'd1,
    PAT_BARS  = 2'd2,
    PAT_CHECK = 2'd3
  } pattern_e;

  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  pattern_e      pat_q, pat_d, pat_eff;
  logic          hs_q, hs_d, vs_q, vs_d, vis_q, vis_d, fs_q, fs_d;
  logic [9:0]    video_q, video_d, pix, noise;
  logic [7:0]    fc_q, fc_d;
  logic          origin, vis_now;

`ifdef HP_EMU_NOISE_EN
  logic [15:0] lfsr_q, lfsr_d;

  // Fibonacci LFSR, taps 16,14,13,11.
  always_comb begin
    lfsr_d = lfsr_q;
    if (ENABLE) lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    noise = {8'd0, lfsr_q[1:0]};
  end

  always_ff @(posedge CLK) begin
    if (RESET) lfsr_q <= 16'hACE1;
    else       lfsr_q <= lfsr_d;
  end
`else
  assign noise = 10'd0;
`endif

  // Raster counters; disabled generator parks at the frame origin.
  always_comb begin
    h_d = h_q;
    v_d = v_q;
    if (!ENABLE) begin
      h_d = '0;
      v_d = '0;
    end else if (h_q == H_LAST) begin
      h_d = '0;
      v_d = (v_q == V_LAST) ? '0 : v_q + VW'(1);
    end else begin
      h_d = h_q + HW'(1);
    end
  end

  // Output stage; the origin pixel uses the freshly sampled pattern so frames never tear.
  always_comb begin
    origin  = (h_q == '0) && (v_q == '0);
    vis_now = (h_q < H_VIS) && (v_q < V_VIS);
    pat_eff = origin ? pattern_e'(PATTERN) : pat_q;
    pix     = BLACK_LEVEL;
    unique case (pat_eff)
      PAT_BLACK: pix = BLACK_LEVEL;
      PAT_WHITE: pix = WHITE_LEVEL;
      PAT_BARS:  pix = h_q[3] ? WHITE_LEVEL : BLACK_LEVEL;
      PAT_CHECK: pix = (h_q[4] ^ v_q[4]) ? WHITE_LEVEL : BLACK_LEVEL;
      default:   pix = BLACK_LEVEL;
    endcase

    hs_d    = ~SYNC_ON;
    vs_d    = ~SYNC_ON;
    video_d = BLACK_LEVEL;
    vis_d   = 1'b0;
    fs_d    = 1'b0;
    pat_d   = pat_q;
    if (ENABLE) begin
      if ((h_q >= H_SSTRT) && (h_q < H_SEND)) hs_d = SYNC_ON;
      if ((v_q >= V_SSTRT) && (v_q < V_SEND)) vs_d = SYNC_ON;
      vis_d = vis_now;
      if (vis_now) video_d = pix ^ noise;
      fs_d = origin;
      if (origin) pat_d = pattern_e'(PATTERN);
    end
    fc_d = fc_q + {7'd0, fs_d};
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      h_q     <= '0;
      v_q     <= '0;
      pat_q   <= PAT_BLACK;
      hs_q    <= ~SYNC_ON;
      vs_q    <= ~SYNC_ON;
      video_q <= BLACK_LEVEL;
      vis_q   <= 1'b0;
      fs_q    <= 1'b0;
      fc_q    <= 8'd0;
    end else begin
      h_q     <= h_d;
      v_q     <= v_d;
      pat_q   <= pat_d;
      hs_q    <= hs_d;
      vs_q    <= vs_d;
      video_q <= video_d;
      vis_q   <= vis_d;
      fs_q    <= fs_d;
      fc_q    <= fc_d;
    end
  end

  assign O_HS        = hs_q;
  assign O_VS        = vs_q;
  assign VIDEO       = video_q;
  assign O_VISIBLE   = vis_q;
  assign FRAME_START = fs_q;
  assign FRAME_COUNT = fc_q;

endmodule

// File: tb/tb_hp_video_emulator.sv
// Scoreboard bench for hp_video_emulator on a reduced raster (88 x 50) so several frames fit in a short run.
module tb_hp_video_emulator;

  localparam int HV = 64, HF = 4, HS = 8, HB = 12;
  localparam int VV = 40, VF = 2, VS = 3, VB = 5;
  localparam int HT = HV + HF + HS + HB;
  localparam int VT = VV + VF + VS + VB;

  logic       clk = 1'b0;
  logic       rst, en;
  logic [1:0] pat;
  logic       o_hs, o_vs, o_vis, fs;
  logic [9:0] video;
  logic [7:0] fc;

  hp_video_emulator #(
    .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .SYNC_ACTIVE_HIGH(1'b0), .BLACK_LEVEL(10'd64), .WHITE_LEVEL(10'd940)
  ) dut (
    .CLK(clk), .RESET(rst), .ENABLE(en), .PATTERN(pat),
    .O_HS(o_hs), .O_VS(o_vs), .VIDEO(video), .O_VISIBLE(o_vis),
    .FRAME_START(fs), .FRAME_COUNT(fc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       hs;
    logic       vs;
    logic [9:0] video;
    logic       vis;
    logic       fs;
    logic [7:0] fc;
  } out_t;

  out_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, req);
    end
  endtask

  // Reference model of the raster position and frame state.
  int         mx = 0, my = 0;
  logic [1:0] mshadow = 2'd0;
  logic [7:0] mfc = 8'd0;

  task automatic step();
    out_t       e;
    logic [1:0] p;
    e = '{hs: 1'b1, vs: 1'b1, video: 10'd64, vis: 1'b0, fs: 1'b0, fc: mfc};
    if (rst) begin
      mx = 0; my = 0; mshadow = 2'd0; mfc = 8'd0; e.fc = 8'd0;
    end else if (!en) begin
      mx = 0; my = 0;
    end else begin
      p     = (mx == 0 && my == 0) ? pat : mshadow;
      e.vis = (mx < HV) && (my < VV);
      e.hs  = !((mx >= HV + HF) && (mx < HV + HF + HS));
      e.vs  = !((my >= VV + VF) && (my < VV + VF + VS));
      if (e.vis) begin
        case (p)
          2'd0:    e.video = 10'd64;
          2'd1:    e.video = 10'd940;
          2'd2:    e.video = ((mx & 8) != 0) ? 10'd940 : 10'd64;
          default: e.video = ((((mx ^ my) >> 4) & 1) != 0) ? 10'd940 : 10'd64;
        endcase
      end
      if (mx == 0 && my == 0) begin
        e.fs = 1'b1; mfc = mfc + 8'd1; mshadow = pat; e.fc = mfc;
      end
      mx++;
      if (mx == HT) begin
        mx = 0; my++;
        if (my == VT) my = 0;
      end
    end
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Monitor: pops one expected sample per clock and measures sync/frame timing.
  int cyc = 0, hs_run = 0, hs_w = 0, vs_run = 0, vs_w = 0, last_fs = -1, fs_per = 0;

  always @(negedge clk) begin
    out_t e, a;
    cyc++;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = '{hs: o_hs, vs: o_vs, video: video, vis: o_vis, fs: fs, fc: fc};
`ifdef HP_EMU_NOISE_EN
      if (e.vis) a.video[1:0] = e.video[1:0];
`endif
      check("pixel{hs,vs,video,vis,fs,fc}", 32'(a), 32'(e));
    end
    if (!o_hs) hs_run++;
    else if (hs_run != 0) begin hs_w = hs_run; hs_run = 0; end
    if (!o_vs) vs_run++;
    else if (vs_run != 0) begin vs_w = vs_run; vs_run = 0; end
    if (fs) begin
      if (last_fs >= 0) fs_per = cyc - last_fs;
      last_fs = cyc;
    end
  end

  initial begin
    rst = 1'b1; en = 1'b0; pat = 2'd0;
    run(3);

    // Reset release into a white frame; two full frames of free run.
    rst = 1'b0; en = 1'b1; pat = 2'd1;
    run(2 * HT * VT);
    @(negedge clk); #1;
    check("frame_start_period", fs_per, 4400);
    check("hsync_low_width", hs_w, 8);
    check("vsync_low_width", vs_w, 264);
    check("frame_count_after_2", fc, 8'd2);

    // Bars selected mid-frame, then checkerboard selected mid-frame.
    pat = 2'd2;
    run(2000);
    run(2400);
    run(2200);
    pat = 2'd3;
    run(2200);
    run(HT * VT);

    // Enable dropped mid-line for 100 cycles, then resumed.
    run(30);
    en = 1'b0;
    run(100);
    en = 1'b1;
    run(300);

    // Reset asserted at line 20, then one full clean frame.
    for (int i = 0; i < 2 * HT * VT && !(my == 20 && mx == 10); i++) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    run(HT * VT);
    @(negedge clk); #1;
    check("frame_count_after_reset", fc, 8'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/hp_video_emulator.md
# hp_video_emulator

Synthetic source for the capture path: generates the same pixel stream the video decoder delivers to the receive side (10-bit luma, HSYNC, VSYNC, visible flag) from a single pixel clock. The timing and test patterns are configurable. It lets the capture logic, line buffer and VGA output be exercised on the bench and in simulation without an HP instrument or decoder attached. In the top level it sits on a debug mux in front of the receive module's `O_HS`, `O_VS` and `VIDEO` inputs.

## Interface
Parameters:
- `H_VISIBLE`, 512: active pixels per line
- `H_FRONT`, 16: front-porch pixels
- `H_SYNC`, 32: hsync width in pixels
- `H_BACK`, 80: back-porch pixels (H_TOTAL = 640)
- `V_VISIBLE`, 384: active lines per frame
- `V_FRONT`, 4: front-porch lines
- `V_SYNC`, 4: vsync width in lines
- `V_BACK`, 24: back-porch lines (V_TOTAL = 416)
- `SYNC_ACTIVE_HIGH`, 0: sync polarity (0 = active low)
- `BLACK_LEVEL`, 10'd64: video code for black and for blanking
- `WHITE_LEVEL`, 10'd940: video code for white

Ports:
- `CLK`  input  1  pixel clock
- `RESET`  input  1  synchronous, active-high reset
- `ENABLE`  input  1  run generator; low = hold at frame origin
- `PATTERN`  input  2  0 black, 1 white, 2 vertical bars, 3 checkerboard
- `O_HS`  output  1  horizontal sync
- `O_VS`  output  1  vertical sync
- `VIDEO`  output  10  luma sample
- `O_VISIBLE`  output  1  high during active pixels
- `FRAME_START`  output  1  one-cycle pulse at pixel (0,0)
- `FRAME_COUNT`  output  8  frames generated, wraps at 255→0

## Operation
- Counters:
  - `h_cnt` counts 0..H_TOTAL-1, wraps to 0; on the wrap, `v_cnt` increments.
  - `v_cnt` counts 0..V_TOTAL-1, wraps to 0.
  - Widths are $clog2(total).
- Line layout on `h_cnt`: visible [0, H_VISIBLE), front porch, sync, back porch.
- Frame layout on `v_cnt`: visible, front porch, sync, back porch, in the same order.
- Sync assertion: `O_HS` asserts while h_cnt is in [H_VISIBLE+H_FRONT, +H_SYNC). `O_VS` asserts while v_cnt is in the matching vertical window; it changes only at h_cnt = 0.
- Visibility: `O_VISIBLE` = (h_cnt < H_VISIBLE) && (v_cnt < V_VISIBLE).
- VIDEO values:
  - Blanking: BLACK_LEVEL.
  - Visible, by pattern: 0 → BLACK; 1 → WHITE; 2 → WHITE if x[3] else BLACK (8-pixel bars); 3 → WHITE if x[4]^y[4] else BLACK (16×16 squares).
  - x is h_cnt and y is v_cnt.
- `PATTERN` is sampled into a shadow register only at h_cnt = 0, v_cnt = 0. A mid-frame change takes effect at the next frame, so no frame is ever torn.
- `ENABLE` low:
  - Counters are held at (0,0).
  - Outputs show the blanking state: syncs inactive, VIDEO = BLACK, O_VISIBLE = 0, no FRAME_START.
- `ENABLE` rising: the first cycle runs from (0,0), and FRAME_START pulses for that frame.
- `FRAME_COUNT` increments on each FRAME_START.

## Timing
- All outputs are registered and lag the counter state by exactly 1 cycle.
- Pixel (0,0) appears on VIDEO in the cycle after the counters reach (0,0); FRAME_START is high in that same cycle.
- Reset values:
  - Counters 0.
  - O_HS = O_VS = inactive level (1 when SYNC_ACTIVE_HIGH = 0).
  - VIDEO = BLACK_LEVEL.
  - O_VISIBLE = 0, FRAME_START = 0, FRAME_COUNT = 0.
  - Pattern shadow = 0.
- RESET mid-frame: all of the above apply on the next edge, and the frame restarts from (0,0) once RESET drops. A partial frame is not counted.
- RESET has priority over ENABLE.
- Simultaneous h and v wrap: both counters go to 0 in the same cycle, and the pattern is latched in that cycle.
- Line period is H_TOTAL cycles; frame period is H_TOTAL × V_TOTAL cycles (266240 with defaults).

## Configuration
- `HP_EMU_NOISE_EN` defined:
  - A 16-bit Fibonacci LFSR (taps 16,14,13,11; seed 16'hACE1 on RESET) advances every enabled cycle.
  - Its two LSBs are XORed into VIDEO[1:0] during visible pixels only. This exercises the receiver's thresholding.
  - Blanking stays exactly BLACK_LEVEL.
- Not defined: no LFSR is instantiated and VIDEO is noise-free.

## Test plan
- Reset, then ENABLE=1, PATTERN=1 → FRAME_START one cycle after RESET drops, VIDEO=940 for 512 cycles then 64; FRAME_COUNT=1.
- Free run with defaults → O_HS low for exactly 32 cycles every 640 cycles starting at cycle 528 of the line; O_VS low for 4 lines (2560 cycles) starting at line 388; FRAME_START period 266240.
- PATTERN=2 → visible pixels 0–7 = 64, 8–15 = 940, repeating. Switching to 3 mid-frame gives no change until the next FRAME_START; from then on it is 16×16 squares (line 16 is inverted relative to line 0).
- ENABLE dropped mid-line for 100 cycles → outputs idle (VIDEO=64, syncs high, O_VISIBLE=0). On re-enable, FRAME_START pulses and FRAME_COUNT increments.
- RESET asserted at line 200 → the next cycle has all outputs at reset values and FRAME_COUNT=0; the frame restarts cleanly.
- With HP_EMU_NOISE_EN, PATTERN=1 → VIDEO[9:2] constant at 940's upper bits and [1:0] varying during visible pixels; blanking exactly 64.
